// File: rtl/key_press_bcd_counter_pkg.sv
// rtl/key_press_bcd_counter_pkg.sv - shared segment codes and debounce FSM encoding
// Segment codes are active-low with the decimal point in bit 0.
// These codes are shared with the seven-segment display controller.
package key_press_bcd_counter_pkg;

  localparam logic [7:0] SEG_ZERO  = 8'h03;
  localparam logic [7:0] SEG_ONE   = 8'h9F;
  localparam logic [7:0] SEG_TWO   = 8'h25;
  localparam logic [7:0] SEG_THREE = 8'h0D;
  localparam logic [7:0] SEG_FOUR  = 8'h99;
  localparam logic [7:0] SEG_FIVE  = 8'h49;
  localparam logic [7:0] SEG_SIX   = 8'h41;
  localparam logic [7:0] SEG_SEVEN = 8'h1F;
  localparam logic [7:0] SEG_EIGHT = 8'h01;
  localparam logic [7:0] SEG_NINE  = 8'h09;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef logic [1:0] state_t;

  localparam state_t IDLE      = 2'd0;
  localparam state_t PRESS_CHK = 2'd1;
  localparam state_t DOWN      = 2'd2;
  localparam state_t REL_CHK   = 2'd3;

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational BCD digit to active-low segment code
// Any value above 9 cannot come from a BCD counter, so it shows as blank.
module bcd_to_seg7
  import key_press_bcd_counter_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  // Decode one digit to its segment pattern.
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_ZERO;
      4'd1:    seg = SEG_ONE;
      4'd2:    seg = SEG_TWO;
      4'd3:    seg = SEG_THREE;
      4'd4:    seg = SEG_FOUR;
      4'd5:    seg = SEG_FIVE;
      4'd6:    seg = SEG_SIX;
      4'd7:    seg = SEG_SEVEN;
      4'd8:    seg = SEG_EIGHT;
      4'd9:    seg = SEG_NINE;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/key_press_bcd_counter.sv
// rtl/key_press_bcd_counter.sv - debounced push-button with two-digit BCD press count
// The raw key passes through a two-flop synchroniser and a four-state debounce FSM.
// Accepted presses increment a 00-99 BCD count.
// The count is then registered into segment codes for the display controller.
module key_press_bcd_counter
  import key_press_bcd_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 3000000,
  parameter int CNT_W           = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  input  logic       clr,
  output logic       key_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_units,
  output logic       overflow,
  output logic [7:0] seg_tens,
  output logic [7:0] seg_units
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s1_d;
  logic             key_sync_q, key_sync_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_level_q, key_level_d;
  logic             press_pulse_q, press_pulse_d;
  logic             release_pulse_q, release_pulse_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       units_q, units_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       seg_tens_q, seg_tens_d;
  logic [7:0]       seg_units_q, seg_units_d;

  // Synchroniser inputs: key_in -> s1 -> key_sync.
  always_comb begin
    s1_d       = key_in;
    key_sync_d = s1_q;
  end

  // State register plus the registered FSM outputs, so they change with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q            <= 1'b0;
      key_sync_q      <= 1'b0;
      state_q         <= IDLE;
      cnt_q           <= '0;
      key_level_q     <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
    end else begin
      s1_q            <= s1_d;
      key_sync_q      <= key_sync_d;
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      key_level_q     <= key_level_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
    end
  end

  // Next state: a transition is accepted only after key_sync stays stable long enough.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (key_sync_q) begin
          state_d = PRESS_CHK;
          cnt_d   = '0;
        end
      end
      PRESS_CHK: begin
        if (!key_sync_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DOWN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DOWN: begin
        if (!key_sync_q) begin
          state_d = REL_CHK;
          cnt_d   = '0;
        end
      end
      REL_CHK: begin
        if (key_sync_q) begin
          state_d = DOWN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM outputs: the level follows the next state, and pulses mark the accepting transitions.
  always_comb begin
    key_level_d     = (state_d == DOWN) || (state_d == REL_CHK);
    press_pulse_d   = (state_q == PRESS_CHK) && (state_d == DOWN);
    release_pulse_d = (state_q == REL_CHK) && (state_d == IDLE);
  end

  // BCD count update: clear beats a same-cycle press; 99 wraps to 00 with overflow.
  always_comb begin
    tens_d     = tens_q;
    units_d    = units_q;
    overflow_d = 1'b0;
    if (clr) begin
      tens_d  = 4'd0;
      units_d = 4'd0;
    end else if (press_pulse_q) begin
      if (units_q < 4'd9) begin
        units_d = units_q + 4'd1;
      end else begin
        units_d = 4'd0;
        if (tens_q < 4'd9) begin
          tens_d = tens_q + 4'd1;
        end else begin
          tens_d     = 4'd0;
          overflow_d = 1'b1;
        end
      end
    end
  end

  // Count and overflow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tens_q     <= 4'd0;
      units_q    <= 4'd0;
      overflow_q <= 1'b0;
    end else begin
      tens_q     <= tens_d;
      units_q    <= units_d;
      overflow_q <= overflow_d;
    end
  end

  bcd_to_seg7 u_seg_tens (
    .bcd (tens_q),
    .seg (seg_tens_d)
  );

  bcd_to_seg7 u_seg_units (
    .bcd (units_q),
    .seg (seg_units_d)
  );

  // Segment registers trail the count by one cycle, so the display sees clean codes.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_tens_q  <= SEG_ZERO;
      seg_units_q <= SEG_ZERO;
    end else begin
      seg_tens_q  <= seg_tens_d;
      seg_units_q <= seg_units_d;
    end
  end

  assign key_level     = key_level_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign bcd_tens      = tens_q;
  assign bcd_units     = units_q;
  assign overflow      = overflow_q;
  assign seg_tens      = seg_tens_q;
  assign seg_units     = seg_units_q;

endmodule

// File: tb/tb_key_press_bcd_counter.sv
// tb/tb_key_press_bcd_counter.sv - scoreboard bench for key_press_bcd_counter
module tb_key_press_bcd_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_in;
  logic       clr;
  logic       key_level;
  logic       press_pulse;
  logic       release_pulse;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_units;
  logic       overflow;
  logic [7:0] seg_tens;
  logic [7:0] seg_units;

  int checks = 0;
  int fails  = 0;
  int model_cnt = 0;

  logic [8:0] exp_q [$];
  logic [8:0] obs_q [$];
  logic [7:0] prev_cnt = 8'h00;
  logic [7:0] seg_tab [0:9] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
                                8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};

  key_press_bcd_counter #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .key_in        (key_in),
    .clr           (clr),
    .key_level     (key_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .bcd_tens      (bcd_tens),
    .bcd_units     (bcd_units),
    .overflow      (overflow),
    .seg_tens      (seg_tens),
    .seg_units     (seg_units)
  );

  always #5 clk = ~clk;

  // Capture each count change (or overflow pulse) produced by the DUT.
  always @(negedge clk) begin
    if (!rst && (({bcd_tens, bcd_units} != prev_cnt) || overflow))
      obs_q.push_back({overflow, bcd_tens, bcd_units});
    prev_cnt = {bcd_tens, bcd_units};
  end

  function automatic logic [8:0] pack(input int c, input logic o);
    return {o, 4'(c / 10), 4'(c % 10)};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_press();
    if (model_cnt == 99) begin
      model_cnt = 0;
      exp_q.push_back(pack(0, 1'b1));
    end else begin
      model_cnt++;
      exp_q.push_back(pack(model_cnt, 1'b0));
    end
  endtask

  task automatic drive_press();
    push_press();
    key_in = 1'b1;
    repeat (10) tick();
    key_in = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; key_in = 1'b0; clr = 1'b0;
    repeat (3) tick();
    checks++;
    if ({key_level, press_pulse, release_pulse, overflow} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_flags: got %b expected 0000", {key_level, press_pulse, release_pulse, overflow});
    end
    checks++;
    if ({bcd_tens, bcd_units} !== 8'h00) begin
      fails++;
      $display("FAIL reset_bcd: got %h expected 00", {bcd_tens, bcd_units});
    end
    checks++;
    if ({seg_tens, seg_units} !== 16'h0303) begin
      fails++;
      $display("FAIL reset_seg: got %h expected 0303", {seg_tens, seg_units});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_bounce();
    logic bad_pulse = 1'b0;
    logic bad_level = 1'b0;
    key_in = 1'b1; repeat (3) tick();
    key_in = 1'b0; repeat (2) tick();
    key_in = 1'b1; repeat (2) tick();
    key_in = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if (press_pulse !== 1'b0) bad_pulse = 1'b1;
      if (key_level !== 1'b0) bad_level = 1'b1;
      tick();
    end
    checks++;
    if (bad_pulse) begin
      fails++;
      $display("FAIL bounce_pulse: got press_pulse=1 expected 0");
    end
    checks++;
    if (bad_level) begin
      fails++;
      $display("FAIL bounce_level: got key_level=1 expected 0");
    end
    checks++;
    if (obs_q.size() != 0 || {bcd_tens, bcd_units} !== 8'h00) begin
      fails++;
      $display("FAIL bounce_count: got %h (%0d events) expected 00", {bcd_tens, bcd_units}, obs_q.size());
    end
  endtask

  task automatic test_clean_press();
    logic [8:0] got, exp;
    push_press();
    key_in = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      tick();
      checks++;
      if (press_pulse !== (k == 6)) begin
        fails++;
        $display("FAIL press_pulse_edge%0d: got %b expected %b", k, press_pulse, (k == 6));
      end
      checks++;
      if (key_level !== (k >= 6)) begin
        fails++;
        $display("FAIL press_level_edge%0d: got %b expected %b", k, key_level, (k >= 6));
      end
      if (k == 7) begin
        checks++;
        if (bcd_units !== 4'd1) begin
          fails++;
          $display("FAIL press_units_edge7: got %0d expected 1", bcd_units);
        end
      end
      if (k == 8) begin
        checks++;
        if (seg_units !== 8'h9F) begin
          fails++;
          $display("FAIL press_seg_edge8: got %h expected 9f", seg_units);
        end
      end
    end
    checks++;
    if (obs_q.size() == 0) begin
      fails++;
      $display("FAIL press_sb: got no count event expected %h", exp_q[0]);
    end else begin
      got = obs_q.pop_front();
      exp = exp_q.pop_front();
      if (got !== exp) begin
        fails++;
        $display("FAIL press_sb: got %h expected %h", got, exp);
      end
    end
  endtask

  task automatic test_release();
    logic bad = 1'b0;
    key_in = 1'b0; repeat (2) tick();
    key_in = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (release_pulse !== 1'b0 || key_level !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      fails++;
      $display("FAIL release_glitch: got release or level drop expected none");
    end
    key_in = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      tick();
      checks++;
      if (release_pulse !== (k == 6)) begin
        fails++;
        $display("FAIL release_pulse_edge%0d: got %b expected %b", k, release_pulse, (k == 6));
      end
      checks++;
      if (key_level !== (k < 6)) begin
        fails++;
        $display("FAIL release_level_edge%0d: got %b expected %b", k, key_level, (k < 6));
      end
    end
    checks++;
    if (obs_q.size() != 0 || {bcd_tens, bcd_units} !== 8'h01) begin
      fails++;
      $display("FAIL release_count: got %h (%0d events) expected 01", {bcd_tens, bcd_units}, obs_q.size());
    end
  endtask

  task automatic test_carry_wrap();
    logic [8:0] got, exp;
    for (int i = 0; i < 99; i++) begin
      drive_press();
      checks++;
      if (obs_q.size() == 0) begin
        fails++;
        $display("FAIL wrap_sb_%0d: got no count event expected %h", i, exp_q[0]);
      end else begin
        got = obs_q.pop_front();
        exp = exp_q.pop_front();
        if (got !== exp) begin
          fails++;
          $display("FAIL wrap_sb_%0d: got %h expected %h", i, got, exp);
        end
      end
      checks++;
      if (seg_tens !== seg_tab[model_cnt / 10] || seg_units !== seg_tab[model_cnt % 10]) begin
        fails++;
        $display("FAIL wrap_seg_%0d: got %h%h expected %h%h", model_cnt, seg_tens, seg_units,
                 seg_tab[model_cnt / 10], seg_tab[model_cnt % 10]);
      end
    end
    checks++;
    if (obs_q.size() != 0 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL wrap_tail: got %0d extra events, overflow=%b expected 0 and 0", obs_q.size(), overflow);
    end
  endtask

  task automatic test_clear();
    logic [8:0] got, exp;
    logic found = 1'b0;
    repeat (5) drive_press();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs_q.size() == 0) begin
        fails++;
        $display("FAIL clear_pre_%0d: got no count event expected %h", i, exp_q[0]);
      end else begin
        got = obs_q.pop_front();
        exp = exp_q.pop_front();
        if (got !== exp) begin
          fails++;
          $display("FAIL clear_pre_%0d: got %h expected %h", i, got, exp);
        end
      end
    end
    key_in = 1'b1;
    for (int k = 0; k < 12 && !found; k++) begin
      tick();
      if (press_pulse === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      fails++;
      $display("FAIL clear_wait: got no press_pulse within 12 cycles expected one");
    end
    clr = 1'b1;
    model_cnt = 0;
    exp_q.push_back(pack(0, 1'b0));
    tick();
    clr = 1'b0;
    checks++;
    if ({overflow, bcd_tens, bcd_units} !== 9'h000) begin
      fails++;
      $display("FAIL clear_prio: got %h expected 000", {overflow, bcd_tens, bcd_units});
    end
    key_in = 1'b0;
    repeat (10) tick();
    drive_press();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs_q.size() == 0) begin
        fails++;
        $display("FAIL clear_post_%0d: got no count event expected %h", i, exp_q[0]);
      end else begin
        got = obs_q.pop_front();
        exp = exp_q.pop_front();
        if (got !== exp) begin
          fails++;
          $display("FAIL clear_post_%0d: got %h expected %h", i, got, exp);
        end
      end
    end
  endtask

  task automatic test_reset_abort();
    logic bad = 1'b0;
    key_in = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    key_in = 1'b0;
    model_cnt = 0;
    repeat (2) tick();
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (press_pulse !== 1'b0 || release_pulse !== 1'b0 || key_level !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      fails++;
      $display("FAIL abort_pulse: got pulse or level after mid-debounce reset expected none");
    end
    checks++;
    if ({bcd_tens, bcd_units, seg_tens, seg_units} !== 24'h000303) begin
      fails++;
      $display("FAIL abort_state: got %h expected 000303", {bcd_tens, bcd_units, seg_tens, seg_units});
    end
  endtask

  initial begin
    rst = 1'b1; key_in = 1'b0; clr = 1'b0;
    tick();
    test_reset();
    test_bounce();
    test_clean_press();
    test_release();
    test_carry_wrap();
    test_clear();
    test_reset_abort();
    checks++;
    if (obs_q.size() != 0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: got %0d observed / %0d expected left expected 0/0", obs_q.size(), exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
